// File: rtl/merge_arb_pkg.sv
// Shared types and helpers for the two-requester merge arbiter and the
// benches that drive the 4-phase merge element's select channel.
package merge_arb_pkg;

    // Handshake sequencing states of the arbiter.
    typedef enum logic [1:0] {
        IDLE,
        SEND,
        RTZ,
        GRANT
    } arb_state_t;

    // Select token carried on the merge S channel: 0 routes A, 1 routes B.
    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } sel_t;

    // Width of the burst counter; BURST is limited to 1..15.
    localparam int BURST_W = 4;

    // Number of asynchronous inputs that need synchronizing.
    localparam int N_SYNC = 3;

    // The requester that is not s.
    function automatic sel_t sel_other(input sel_t s);
        return (s == SEL_A) ? SEL_B : SEL_A;
    endfunction

    // Increment that saturates at limit.
    function automatic logic [BURST_W-1:0] burst_next(
        input logic [BURST_W-1:0] cnt,
        input logic [BURST_W-1:0] limit
    );
        return (cnt >= limit) ? limit : cnt + BURST_W'(1);
    endfunction

endpackage

// File: rtl/merge_arbiter_sync2.sv
// Two-flop synchronizer for a single level signal crossing into clk.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    // Two back-to-back flops; only the second one is used downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/merge_arbiter.sv
// Round-robin arbiter with burst allowance that sequences a 2-input 4-phase
// merge: it picks the next owner, sends the select token on the S channel,
// then acknowledges the winning requester and counts its grant.
module merge_arbiter
    import merge_arb_pkg::*;
#(
    parameter int BURST = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    output logic             ack_a,
    input  logic             req_b,
    output logic             ack_b,
    output logic             s_req,
    output logic             s_data,
    input  logic             s_ack,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    localparam logic [BURST_W-1:0] BURST_C = BURST_W'(BURST);

    // Asynchronous inputs, bit order {s_ack, req_b, req_a}.
    logic [N_SYNC-1:0] w_async;
    logic [N_SYNC-1:0] w_sync;

    logic w_req_a_s;
    logic w_req_b_s;
    logic w_s_ack_s;
    logic w_any_req;
    logic w_req_own_s;
    logic w_burst_live;
    sel_t w_winner;

    arb_state_t        r_state;
    sel_t              r_owner;
    sel_t              r_last;
    logic [BURST_W-1:0] r_burst_cnt;
    logic              r_s_req;
    logic              r_s_data;
    logic              r_ack_a;
    logic              r_ack_b;
    logic [CNT_W-1:0]  r_cnt_a;
    logic [CNT_W-1:0]  r_cnt_b;

    assign w_async = {s_ack, req_b, req_a};

    genvar gi;
    generate
        for (gi = 0; gi < N_SYNC; gi++) begin : g_sync
            sync2 u_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .i_d   (w_async[gi]),
                .o_q   (w_sync[gi])
            );
        end
    endgenerate

    assign w_req_a_s = w_sync[0];
    assign w_req_b_s = w_sync[1];
    assign w_s_ack_s = w_sync[2];

    assign w_any_req   = w_req_a_s | w_req_b_s;
    assign w_req_own_s = (r_owner == SEL_B) ? w_req_b_s : w_req_a_s;

    // The previous winner may keep the grant only if it actually holds a
    // running burst; a zero count (after reset) means nobody has won yet,
    // so the first tie goes to the requester opposite the reset value of
    // r_last, i.e. A.
    assign w_burst_live = (r_burst_cnt != '0) && (r_burst_cnt < BURST_C);

    // Winner selection among the synchronized requests.
    always_comb begin
        w_winner = SEL_A;
        if (w_req_a_s && !w_req_b_s) begin
            w_winner = SEL_A;
        end else if (!w_req_a_s && w_req_b_s) begin
            w_winner = SEL_B;
        end else if (w_burst_live) begin
            w_winner = r_last;
        end else begin
            w_winner = sel_other(r_last);
        end
    end

    // Handshake FSM with burst/last bookkeeping and grant counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_owner     <= SEL_A;
            r_last      <= SEL_B;
            r_burst_cnt <= '0;
            r_s_req     <= 1'b0;
            r_s_data    <= 1'b0;
            r_ack_a     <= 1'b0;
            r_ack_b     <= 1'b0;
            r_cnt_a     <= '0;
            r_cnt_b     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_owner  <= w_winner;
                        r_s_data <= w_winner;
                        r_s_req  <= 1'b1;
                        r_state  <= SEND;
                        if (w_winner == r_last) begin
                            r_burst_cnt <= burst_next(r_burst_cnt, BURST_C);
                        end else begin
                            r_burst_cnt <= BURST_W'(1);
                            r_last      <= w_winner;
                        end
                    end
                end
                SEND: begin
                    if (w_s_ack_s) begin
                        r_s_req <= 1'b0;
                        r_state <= RTZ;
                    end
                end
                RTZ: begin
                    if (!w_s_ack_s) begin
                        r_ack_a <= (r_owner == SEL_A);
                        r_ack_b <= (r_owner == SEL_B);
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (!w_req_own_s) begin
                        r_ack_a <= 1'b0;
                        r_ack_b <= 1'b0;
                        if (r_owner == SEL_A) begin
                            r_cnt_a <= r_cnt_a + CNT_W'(1);
                        end else begin
                            r_cnt_b <= r_cnt_b + CNT_W'(1);
                        end
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ack_a  = r_ack_a;
    assign ack_b  = r_ack_b;
    assign s_req  = r_s_req;
    assign s_data = r_s_data;
    assign cnt_a  = r_cnt_a;
    assign cnt_b  = r_cnt_b;

endmodule

// File: tb/tb_merge_arbiter.sv
// Bench for merge_arbiter: three instances (BURST=1, BURST=3, CNT_W=2)
// driven by a requester/merge environment, a vector table, hand-timed
// latency/reset sequences and randomized runs against a reference model.
`timescale 1ns/1ps
module tb_merge_arbiter;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic req_a  [N];
    logic req_b  [N];
    logic s_ack  [N];
    logic ack_a  [N];
    logic ack_b  [N];
    logic s_req  [N];
    logic s_data [N];
    logic [7:0] cnt_a0, cnt_b0, cnt_a1, cnt_b1;
    logic [1:0] cnt_a2, cnt_b2;

    merge_arbiter #(.BURST(1), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a[0]), .ack_a(ack_a[0]), .req_b(req_b[0]), .ack_b(ack_b[0]),
        .s_req(s_req[0]), .s_data(s_data[0]), .s_ack(s_ack[0]),
        .cnt_a(cnt_a0), .cnt_b(cnt_b0)
    );
    merge_arbiter #(.BURST(3), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a[1]), .ack_a(ack_a[1]), .req_b(req_b[1]), .ack_b(ack_b[1]),
        .s_req(s_req[1]), .s_data(s_data[1]), .s_ack(s_ack[1]),
        .cnt_a(cnt_a1), .cnt_b(cnt_b1)
    );
    merge_arbiter #(.BURST(1), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a[2]), .ack_a(ack_a[2]), .req_b(req_b[2]), .ack_b(ack_b[2]),
        .s_req(s_req[2]), .s_data(s_data[2]), .s_ack(s_ack[2]),
        .cnt_a(cnt_a2), .cnt_b(cnt_b2)
    );

    int checks = 0;
    int failures = 0;

    // environment state
    bit env_on [N];
    bit rand_gap [N];
    int rem_a [N];
    int rem_b [N];
    bit drop_a [N];
    bit drop_b [N];
    int sack_dly [N];
    int sack_cnt [N];

    // monitor / reference model state
    bit h0a [N], h1a [N], h2a [N];
    bit h0b [N], h1b [N], h2b [N];
    bit prev_sreq [N], prev_acka [N], prev_ackb [N];
    int m_last [N];
    int m_burst [N];
    int m_owner [N];
    int mcnt_a [N];
    int mcnt_b [N];
    int nsel [N];
    logic [15:0] seq_rec [N];

    function automatic int burst_of(input int d);
        return (d == 1) ? 3 : 1;
    endfunction

    function automatic int mask_of(input int d);
        return (d == 2) ? 3 : 255;
    endfunction

    function automatic int cnt_of(input int d, input bit b);
        case (d)
            0: return b ? int'(cnt_b0) : int'(cnt_a0);
            1: return b ? int'(cnt_b1) : int'(cnt_a1);
            default: return b ? int'(cnt_b2) : int'(cnt_a2);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference decision: spec round-robin with burst allowance.
    function automatic int model_pick(input int d, input bit a, input bit b);
        int w;
        if (a && !b) w = 0;
        else if (b && !a) w = 1;
        else if (m_burst[d] > 0 && m_burst[d] < burst_of(d)) w = m_last[d];
        else w = 1 - m_last[d];
        if (w == m_last[d]) begin
            m_burst[d] = (m_burst[d] + 1 > burst_of(d)) ? burst_of(d) : m_burst[d] + 1;
        end else begin
            m_burst[d] = 1;
            m_last[d] = w;
        end
        return w;
    endfunction

    task automatic monitor(input int d);
        int w;
        check($sformatf("inv_excl_d%0d", d),
              (s_req[d] & (ack_a[d] | ack_b[d])) | (ack_a[d] & ack_b[d]), 0);
        h2a[d] = h1a[d]; h1a[d] = h0a[d]; h0a[d] = req_a[d];
        h2b[d] = h1b[d]; h1b[d] = h0b[d]; h0b[d] = req_b[d];
        if (env_on[d]) begin
            if (s_req[d] && !prev_sreq[d]) begin
                check($sformatf("spurious_dec_d%0d", d), h2a[d] | h2b[d], 1);
                w = model_pick(d, h2a[d], h2b[d]);
                check($sformatf("sel_d%0d_n%0d", d, nsel[d]), s_data[d], w);
                m_owner[d] = w;
                if (nsel[d] < 16) seq_rec[d][nsel[d]] = s_data[d];
                nsel[d]++;
            end
            if (ack_a[d] && !prev_acka[d]) check($sformatf("ack_a_owner_d%0d", d), m_owner[d], 0);
            if (ack_b[d] && !prev_ackb[d]) check($sformatf("ack_b_owner_d%0d", d), m_owner[d], 1);
            if (!ack_a[d] && prev_acka[d]) begin
                mcnt_a[d] = (mcnt_a[d] + 1) & mask_of(d);
                check($sformatf("cnt_a_d%0d", d), cnt_of(d, 0), mcnt_a[d]);
            end
            if (!ack_b[d] && prev_ackb[d]) begin
                mcnt_b[d] = (mcnt_b[d] + 1) & mask_of(d);
                check($sformatf("cnt_b_d%0d", d), cnt_of(d, 1), mcnt_b[d]);
            end
        end
        prev_sreq[d] = s_req[d];
        prev_acka[d] = ack_a[d];
        prev_ackb[d] = ack_b[d];
    endtask

    task automatic drive(input int d);
        if (drop_a[d] && !ack_a[d]) drop_a[d] = 0;
        if (req_a[d] && ack_a[d] && !drop_a[d]) begin
            req_a[d] = 0; drop_a[d] = 1; rem_a[d]--;
        end else if (!req_a[d] && rem_a[d] > 0 && (!rand_gap[d] || $urandom_range(0, 2) == 0)) begin
            req_a[d] = 1;
        end
        if (drop_b[d] && !ack_b[d]) drop_b[d] = 0;
        if (req_b[d] && ack_b[d] && !drop_b[d]) begin
            req_b[d] = 0; drop_b[d] = 1; rem_b[d]--;
        end else if (!req_b[d] && rem_b[d] > 0 && (!rand_gap[d] || $urandom_range(0, 2) == 0)) begin
            req_b[d] = 1;
        end
        if (s_req[d] != s_ack[d]) begin
            if (sack_cnt[d] >= sack_dly[d]) begin
                s_ack[d] = s_req[d];
                sack_cnt[d] = 0;
                if (rand_gap[d]) sack_dly[d] = $urandom_range(0, 3);
            end else begin
                sack_cnt[d]++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int d = 0; d < N; d++) begin
            monitor(d);
            if (env_on[d]) drive(d);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int d = 0; d < N; d++) begin
            req_a[d] = 0; req_b[d] = 0; s_ack[d] = 0;
            env_on[d] = 0; rand_gap[d] = 0; rem_a[d] = 0; rem_b[d] = 0;
            drop_a[d] = 0; drop_b[d] = 0; sack_dly[d] = 0; sack_cnt[d] = 0;
            m_last[d] = 1; m_burst[d] = 0; m_owner[d] = 0;
            mcnt_a[d] = 0; mcnt_b[d] = 0; nsel[d] = 0; seq_rec[d] = '0;
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        for (int d = 0; d < N; d++) begin
            check($sformatf("rst_outs_d%0d", d),
                  {ack_a[d], ack_b[d], s_req[d], s_data[d]}, 0);
            check($sformatf("rst_cnt_d%0d", d), cnt_of(d, 0) + cnt_of(d, 1), 0);
        end
    endtask

    task automatic start_env(input int d, input int na, input int nb, input bit rnd);
        rem_a[d] = na; rem_b[d] = nb; rand_gap[d] = rnd;
        sack_dly[d] = rnd ? $urandom_range(0, 3) : 0;
        sack_cnt[d] = 0; nsel[d] = 0; seq_rec[d] = '0;
        env_on[d] = 1;
        if (!rnd) begin
            req_a[d] = (na > 0);
            req_b[d] = (nb > 0);
        end
    endtask

    task automatic wait_all_done();
        bit busy;
        int c;
        busy = 1;
        for (c = 0; c < 6000 && busy; c++) begin
            busy = 0;
            for (int d = 0; d < N; d++) begin
                if (env_on[d] && (rem_a[d] != 0 || rem_b[d] != 0 || req_a[d] || req_b[d] ||
                    ack_a[d] || ack_b[d] || s_req[d] || s_ack[d]))
                    busy = 1;
            end
            if (busy) step();
        end
        check("done_timeout", busy, 0);
        step();
        step();
    endtask

    // sel: 0 s_req, 1 ack_a, 2 ack_b
    task automatic wait_sig(input int d, input int sel, input bit val);
        logic v;
        int c;
        v = ~val;
        for (c = 0; c < 200; c++) begin
            v = (sel == 0) ? s_req[d] : (sel == 1) ? ack_a[d] : ack_b[d];
            if (v == val) break;
            step();
        end
        check($sformatf("wait_sig%0d_timeout", sel), v, val);
    endtask

    typedef struct {
        int          dut;
        int          na;
        int          nb;
        int          nsel;
        logic [15:0] seq;
        int          ea;
        int          eb;
    } vec_t;

    localparam int NV = 7;
    vec_t vt [NV];

    initial begin
        logic [15:0] m;
        int d;
        int ta [N];
        int tb [N];

        // {dut, A grants, B grants, #selects, select bits (txn i = bit i), cnt_a, cnt_b}
        vt[0] = '{0, 1, 0, 1, 16'h0000, 1, 0};   // A only
        vt[1] = '{0, 2, 2, 4, 16'h000A, 2, 2};   // BURST=1: A,B,A,B
        vt[2] = '{1, 5, 3, 8, 16'h0038, 5, 3};   // BURST=3: A,A,A,B,B,B,A,A
        vt[3] = '{2, 5, 0, 5, 16'h0000, 1, 0};   // CNT_W=2 wrap: 1,2,3,0,1
        vt[4] = '{0, 3, 1, 4, 16'h0002, 3, 1};   // A,B,A,A
        vt[5] = '{1, 0, 4, 4, 16'h000F, 0, 4};   // B only
        vt[6] = '{1, 2, 4, 6, 16'h003C, 2, 4};   // burst cut short: A,A,B,B,B,B

        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_a[i] = 0; req_b[i] = 0; s_ack[i] = 0;
        end

        for (int v = 0; v < NV; v++) begin
            do_reset();
            d = vt[v].dut;
            start_env(d, vt[v].na, vt[v].nb, 1'b0);
            wait_all_done();
            m = 16'((32'h1 << vt[v].nsel) - 1);
            check($sformatf("v%0d_nsel", v), nsel[d], vt[v].nsel);
            check($sformatf("v%0d_seq", v), seq_rec[d] & m, vt[v].seq);
            check($sformatf("v%0d_cnt_a", v), cnt_of(d, 0), vt[v].ea);
            check($sformatf("v%0d_cnt_b", v), cnt_of(d, 1), vt[v].eb);
            $display("vector %0d dut=%0d sels=%0d seq=%h cnt_a=%0d cnt_b=%0d",
                     v, d, nsel[d], seq_rec[d] & m, cnt_of(d, 0), cnt_of(d, 1));
        end

        // Hand-timed full transaction on instance 0, with a 10-cycle s_ack stall.
        do_reset();
        req_a[0] = 1;
        step(); check("lat_req_n0", s_req[0], 0);
        step(); check("lat_req_n1", s_req[0], 0);
        step(); check("lat_req_n2", s_req[0], 1);
        check("lat_sdata_a", s_data[0], 0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("stall_sreq", s_req[0], 1);
            check("stall_sdata", s_data[0], 0);
            check("stall_no_ack", ack_a[0] | ack_b[0], 0);
        end
        s_ack[0] = 1;
        step(); check("lat_sack_m0", s_req[0], 1);
        step(); check("lat_sack_m1", s_req[0], 1);
        step(); check("lat_sack_m2", s_req[0], 0);
        check("rtz_no_ack", ack_a[0], 0);
        s_ack[0] = 0;
        step(); check("lat_rtz_k0", ack_a[0], 0);
        step(); check("lat_rtz_k1", ack_a[0], 0);
        step(); check("lat_rtz_k2", ack_a[0], 1);
        req_a[0] = 0;
        step(); check("lat_rel_j0", ack_a[0], 1);
        step(); check("lat_rel_j1", ack_a[0], 1);
        check("lat_rel_cnt_j1", cnt_a0, 0);
        step(); check("lat_rel_j2", ack_a[0], 0);
        check("lat_rel_cnt_a", cnt_a0, 1);
        check("lat_rel_cnt_b", cnt_b0, 0);
        $display("hand txn: cnt_a=%0d cnt_b=%0d", cnt_a0, cnt_b0);

        // Reset while instance 0 is in GRANT with ack_b high.
        do_reset();
        start_env(0, 0, 1, 1'b0);
        wait_all_done();
        env_on[0] = 0;
        req_b[0] = 1;
        wait_sig(0, 0, 1'b1);
        s_ack[0] = 1;
        wait_sig(0, 0, 1'b0);
        s_ack[0] = 0;
        wait_sig(0, 2, 1'b1);
        check("pre_rst_cnt_b", cnt_b0, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_ack_b", ack_b[0], 0);
        check("midrst_s_req", s_req[0], 0);
        check("midrst_cnt_b", cnt_b0, 0);
        check("midrst_cnt_a", cnt_a0, 0);
        req_b[0] = 0;
        step();
        rst_n = 1'b1;
        step();
        req_a[0] = 1;
        req_b[0] = 1;
        wait_sig(0, 0, 1'b1);
        check("post_rst_winner", s_data[0], 0);
        $display("reset in GRANT: post-reset winner s_data=%0d", s_data[0]);

        // Randomized runs on all instances against the reference model.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < N; i++) begin
                ta[i] = $urandom_range(0, 12);
                tb[i] = $urandom_range(0, 12);
                start_env(i, ta[i], tb[i], 1'b1);
            end
            wait_all_done();
            for (int i = 0; i < N; i++) begin
                check($sformatf("rnd%0d_nsel_d%0d", r, i), nsel[i], ta[i] + tb[i]);
                check($sformatf("rnd%0d_cnt_a_d%0d", r, i), cnt_of(i, 0), ta[i] & mask_of(i));
                check($sformatf("rnd%0d_cnt_b_d%0d", r, i), cnt_of(i, 1), tb[i] & mask_of(i));
                $display("random %0d dut=%0d grants_a=%0d grants_b=%0d cnt_a=%0d cnt_b=%0d",
                         r, i, ta[i], tb[i], cnt_of(i, 0), cnt_of(i, 1));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
